multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the LEGv8 datapath. It replaces the single-cycle main/ALU control pair with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. Variable-latency memory is supported through a ready handshake with a timeout. The block drives all datapath enables and the ALU operation code, and counts retired instructions.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = FETCH/MEM wait for `mem_ready`; 0 = memory is treated as ready every cycle and `mem_ready` is ignored.
- `WAIT_W`, default 4: width of the memory wait counter.
- `MAX_WAIT`, default 15: waiting cycles allowed before a fault. Range 1..2^WAIT_W-1.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clock` in 1: the only clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instruction` in 32: instruction register contents, held stable by the datapath after `ir_write`.
- `mem_ready` in 1: memory completed the current access this cycle.
- `zero` in 1: ALU zero flag, valid in EXEC.
- `ir_write` out 1: latch the fetched word into the instruction register.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: 0 = PC+4, 1 = branch target.
- `reg2loc` out 1: 1 = read register 2 from Rt (bits 4:0).
- `alu_src` out 1: 1 = ALU B operand is the sign-extended offset.
- `mem_to_reg` out 1: 1 = write-back data comes from memory.
- `reg_write` out 1: register file write enable.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `operation` out 4: ALU operation code.
- `state` out 3: current state, for debug.
- `fault` out 1: sticky fault flag.
- `retired` out CNT_W: count of completed instructions.

## Operation
Decode uses the following opcodes:
- 11-bit `[31:21]`: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000.
- 8-bit `[31:24]`: CBZ 10110100, CBNZ 10110101.
- 6-bit `[31:26]`: B 000101.
- Anything else is illegal.

ALU operation codes: AND 0000, ORR 0001, ADD 0010 (also used for LDUR/STUR address), SUB 0110, pass-B 0111 (CBZ/CBNZ).

States (encoding in brackets):
- **FETCH (0):**
  - Outputs: `mem_read`=1.
  - Exit when ready (mem_ready, or always if MEM_HANDSHAKE=0): `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- **DECODE (1):**
  - `reg2loc`=1 for STUR/CBZ/CBNZ.
  - Illegal instruction: go to FAULT.
  - B: `pc_write`=1, `pc_src`=1, `retired`++, then go to FETCH.
  - Otherwise: go to EXEC.
- **EXEC (2):**
  - Outputs: `operation` per the table above; `alu_src`=1 for LDUR/STUR; `reg2loc` held as in DECODE.
  - R-type: go to WB.
  - LDUR/STUR: go to MEM.
  - CBZ/CBNZ: taken = `zero` for CBZ, `!zero` for CBNZ. Drive `pc_write`=taken and `pc_src`=1, `retired`++, then go to FETCH.
- **MEM (3):**
  - LDUR drives `mem_read`=1; STUR drives `mem_write`=1. `alu_src`=1 and `operation`=0010 are held.
  - On ready: LDUR goes to WB; STUR does `retired`++ and goes to FETCH.
- **WB (4):**
  - Outputs: `reg_write`=1; `mem_to_reg`=1 for LDUR only.
  - `retired`++, then go to FETCH.
- **FAULT (5):**
  - All enables are 0 and `fault`=1.
  - The block stays here until reset.

Wait counter:
- Cleared on entry to FETCH and MEM.
- Increments each cycle the ready condition is not met in those states.
- When it reaches MAX_WAIT with ready still low, the next state is FAULT and no memory enables are asserted afterward.
- If ready arrives on the same cycle the count reaches MAX_WAIT, ready wins.

`retired` wraps from 2^CNT_W-1 to 0.

Encodings 6 and 7 are unreachable. If reached, they go to FAULT.

## Timing
- **Outputs:** all control outputs are combinational from `state`, `instruction`, `zero` and `mem_ready`. `state`, `fault`, `retired` and the wait counter are registered.
- **Reset:**
  - Asserting `reset_n` low immediately sets state to FETCH, `fault`=0, `retired`=0 and the wait counter to 0.
  - While `reset_n` is low, every control output is forced to 0, including `mem_read`.
  - Reset asserted mid-instruction aborts that instruction with no retire.
- **Latency with zero-wait memory, in cycles:**
  - B: 2
  - CBZ/CBNZ: 3
  - STUR: 4
  - R-type: 4
  - LDUR: 5
- **Memory waits:** each wait cycle in FETCH or MEM adds one cycle.
- **Handshake:** requests stay asserted until the ready cycle inclusive and drop the cycle after.

## Test plan
- Reset release, zero-wait memory, ADD X1,X2,X3 (0x8B030041): states 0,1,2,4,0. `reg_write` high only in WB; `operation`=0010; `retired`=1 after 4 cycles.
- LDUR then STUR with `mem_ready` delayed 3 cycles in MEM: `mem_read` then `mem_write` held for 4 cycles each. `mem_to_reg`=1 in WB for LDUR only; `retired`=2.
- CBZ with `zero`=1 gives `pc_write`=1, `pc_src`=1 in EXEC. CBZ with `zero`=0 gives `pc_write`=0. CBNZ gives the inverse in both cases. `operation`=0111 throughout.
- Illegal word 0x00000000 in DECODE: FAULT, `fault`=1, all enables 0 for 20 cycles. Assert `reset_n` low mid-FAULT: state 0 and `fault`=0 asynchronously.
- `mem_ready` held low with MAX_WAIT=15: FETCH for 16 cycles, then FAULT. Repeat with `mem_ready` high on cycle 16: the instruction proceeds to DECODE instead.
- CNT_W=4, 17 B instructions: `retired` wraps 15 to 0 and ends at 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables and ALU operation, times out stalled memory and counts retirements.
module multicycle_control #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_W        = 4,
    parameter int unsigned MAX_WAIT      = 15,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       operation,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    state_t            state_q, next_state;
    logic              fault_q;
    logic [CNT_W-1:0]  retired_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic       ready, timed_out, retire, wait_inc;
    logic       ir_write_c, pc_write_c, pc_src_c, reg2loc_c, alu_src_c;
    logic       mem_to_reg_c, reg_write_c, mem_read_c, mem_write_c;
    logic [3:0] operation_c;

    // Opcode decode; the instruction register is stable from DECODE onward.
    logic [10:0] op11;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic        is_add, is_sub, is_and, is_orr, is_ld, is_st;
    logic        is_cbz, is_cbnz, is_b, is_rtype, is_cb, is_legal;
    logic        unused_operand_bits;

    assign op11 = instruction[31:21];
    assign op8  = instruction[31:24];
    assign op6  = instruction[31:26];
    assign unused_operand_bits = ^instruction[20:0];

    assign is_add   = (op11 == 11'b10001011000);
    assign is_sub   = (op11 == 11'b11001011000);
    assign is_and   = (op11 == 11'b10001010000);
    assign is_orr   = (op11 == 11'b10101010000);
    assign is_ld    = (op11 == 11'b11111000010);
    assign is_st    = (op11 == 11'b11111000000);
    assign is_cbz   = (op8  == 8'b10110100);
    assign is_cbnz  = (op8  == 8'b10110101);
    assign is_b     = (op6  == 6'b000101);
    assign is_rtype = is_add | is_sub | is_and | is_orr;
    assign is_cb    = is_cbz | is_cbnz;
    assign is_legal = is_rtype | is_ld | is_st | is_cb | is_b;

    assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign timed_out = (wait_cnt == MAX_CNT);

    always_comb begin
        next_state   = state_q;
        retire       = 1'b0;
        wait_inc     = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        reg2loc_c    = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        operation_c  = 4'b0000;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                reg2loc_c = is_st | is_cb;
                if (!is_legal) begin
                    next_state = S_FAULT;
                end else if (is_b) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                reg2loc_c = is_st | is_cb;
                alu_src_c = is_ld | is_st;
                if (is_and)                  operation_c = OP_AND;
                else if (is_orr)             operation_c = OP_ORR;
                else if (is_sub)             operation_c = OP_SUB;
                else if (is_cb)              operation_c = OP_PASS;
                else                         operation_c = OP_ADD;
                if (is_rtype) begin
                    next_state = S_WB;
                end else if (is_ld | is_st) begin
                    next_state = S_MEM;
                end else if (is_cb) begin
                    pc_write_c = is_cbz ? zero : !zero;
                    pc_src_c   = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_MEM: begin
                alu_src_c   = 1'b1;
                operation_c = OP_ADD;
                mem_read_c  = is_ld;
                mem_write_c = !is_ld;
                if (ready) begin
                    if (is_ld) begin
                        next_state = S_WB;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = is_ld;
                retire       = 1'b1;
                next_state   = S_FETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
    end

    // The wait counter only survives while a memory state stalls; any transition clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            fault_q   <= 1'b0;
            retired_q <= '0;
            wait_cnt  <= '0;
        end else begin
            state_q  <= next_state;
            fault_q  <= fault_q | (next_state == S_FAULT);
            wait_cnt <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Control outputs are held low for the whole time reset is asserted.
    assign ir_write   = reset_n & ir_write_c;
    assign pc_write   = reset_n & pc_write_c;
    assign pc_src     = reset_n & pc_src_c;
    assign reg2loc    = reset_n & reg2loc_c;
    assign alu_src    = reset_n & alu_src_c;
    assign mem_to_reg = reset_n & mem_to_reg_c;
    assign reg_write  = reset_n & reg_write_c;
    assign mem_read   = reset_n & mem_read_c;
    assign mem_write  = reset_n & mem_write_c;
    assign operation  = reset_n ? operation_c : 4'b0000;
    assign state      = state_q;
    assign fault      = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state/output sequences built
// from the instruction class and the planned memory wait counts.
module tb_multicycle_control;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    localparam logic [13:0] IR   = 14'h2000;
    localparam logic [13:0] PCW  = 14'h1000;
    localparam logic [13:0] PCS  = 14'h0800;
    localparam logic [13:0] R2L  = 14'h0400;
    localparam logic [13:0] ASRC = 14'h0200;
    localparam logic [13:0] M2R  = 14'h0100;
    localparam logic [13:0] RW   = 14'h0080;
    localparam logic [13:0] MR   = 14'h0040;
    localparam logic [13:0] MW   = 14'h0020;
    localparam logic [13:0] FLT  = 14'h0001;

    localparam logic [31:0] I_ADD  = 32'h8B030041;
    localparam logic [31:0] I_LDUR = 32'hF8408041;
    localparam logic [31:0] I_STUR = 32'hF8010062;
    localparam logic [31:0] I_CBZ  = 32'hB4000085;
    localparam logic [31:0] I_CBNZ = 32'hB5000105;
    localparam logic [31:0] I_B    = 32'h14000010;

    typedef enum int {K_R, K_LD, K_ST, K_CB, K_CBN, K_B, K_ILL} kind_t;

    logic             clock, reset_n, mem_ready, zero;
    logic [31:0]      instruction;
    logic             ir_write, pc_write, pc_src, reg2loc, alu_src;
    logic             mem_to_reg, reg_write, mem_read, mem_write, fault;
    logic [3:0]       operation;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic [13:0]      ctrl;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    multicycle_control #(
        .MEM_HANDSHAKE(1'b1), .WAIT_W(4), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .instruction(instruction),
        .mem_ready(mem_ready), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg2loc(reg2loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .operation(operation), .state(state), .fault(fault), .retired(retired)
    );

    assign ctrl = {ir_write, pc_write, pc_src, reg2loc, alu_src, mem_to_reg,
                   reg_write, mem_read, mem_write, operation, fault};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit rand_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [13:0] opf(input logic [3:0] op);
        return {9'b0, op, 1'b0};
    endfunction

    function automatic kind_t classify(input logic [31:0] w);
        logic [10:0] o11;
        logic [7:0]  o8;
        logic [5:0]  o6;
        o11 = w[31:21];
        o8  = w[31:24];
        o6  = w[31:26];
        if (o11 == 11'b10001011000 || o11 == 11'b11001011000 ||
            o11 == 11'b10001010000 || o11 == 11'b10101010000) return K_R;
        if (o11 == 11'b11111000010) return K_LD;
        if (o11 == 11'b11111000000) return K_ST;
        if (o8 == 8'b10110100) return K_CB;
        if (o8 == 8'b10110101) return K_CBN;
        if (o6 == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [3:0] exp_op(input kind_t k, input logic [31:0] w);
        logic [10:0] o11;
        o11 = w[31:21];
        if (k == K_CB || k == K_CBN) return 4'b0111;
        if (k != K_R) return 4'b0010;
        case (o11)
            11'b11001011000: return 4'b0110;
            11'b10001010000: return 4'b0000;
            11'b10101010000: return 4'b0001;
            default:         return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 8))
            0: return {11'b10001011000, r[20:0]};
            1: return {11'b11001011000, r[20:0]};
            2: return {11'b10001010000, r[20:0]};
            3: return {11'b10101010000, r[20:0]};
            4: return {11'b11111000010, r[20:0]};
            5: return {11'b11111000000, r[20:0]};
            6: return {8'b10110100, r[23:0]};
            7: return {8'b10110101, r[23:0]};
            default: return {6'b000101, r[25:0]};
        endcase
    endfunction

    // Called just after a falling edge: drive, check, then advance to the next falling edge.
    task automatic step(input int st, input bit rdy, input bit z, input logic [13:0] e,
                        input string ph);
        mem_ready = rdy;
        zero      = z;
        #1;
        check({ph, "_state"}, 32'(state), 32'(st));
        check({ph, "_ctrl"}, 32'(ctrl), 32'(e));
        check({ph, "_retired"}, 32'(retired), 32'(exp_ret));
        @(negedge clock);
    endtask

    task automatic bump();
        exp_ret = (exp_ret + 1) % (1 << CNT_W);
    endtask

    task automatic expect_fault(input int n);
        for (int i = 0; i < n; i++) step(5, rand_bit(), rand_bit(), FLT, "fault");
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        @(negedge clock);
        #1;
        check("rst_hold_ctrl", 32'(ctrl), 32'd0);
        check("rst_hold_state", 32'(state), 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        exp_ret   = 0;
    endtask

    // fwait/mwait: cycles before mem_ready rises; above MAX_WAIT means it never does.
    task automatic run_instr(input logic [31:0] w, input int fwait, input int mwait,
                             input int zsel);
        kind_t       k;
        bit          z, rdy, taken;
        logic [13:0] e;
        k = classify(w);
        instruction = w;
        for (int c = 0; c <= fwait && c <= MAX_WAIT; c++) begin
            rdy = (c == fwait);
            step(0, rdy, rand_bit(), MR | (rdy ? (IR | PCW) : 14'h0), "fetch");
        end
        if (fwait > MAX_WAIT) begin
            expect_fault(3);
            return;
        end

        e = (k == K_ST || k == K_CB || k == K_CBN) ? R2L : 14'h0;
        if (k == K_B) e = e | PCW | PCS;
        step(1, rand_bit(), rand_bit(), e, "decode");
        if (k == K_ILL) begin
            expect_fault(20);
            return;
        end
        if (k == K_B) begin
            bump();
            return;
        end

        z = (zsel < 0) ? rand_bit() : bit'(zsel);
        e = opf(exp_op(k, w));
        if (k == K_ST || k == K_CB || k == K_CBN) e = e | R2L;
        if (k == K_LD || k == K_ST) e = e | ASRC;
        if (k == K_CB || k == K_CBN) begin
            taken = (k == K_CB) ? z : !z;
            e = e | PCS | (taken ? PCW : 14'h0);
        end
        step(2, rand_bit(), z, e, "exec");
        if (k == K_CB || k == K_CBN) begin
            bump();
            return;
        end

        if (k == K_LD || k == K_ST) begin
            for (int c = 0; c <= mwait && c <= MAX_WAIT; c++) begin
                rdy = (c == mwait);
                step(3, rdy, rand_bit(), ASRC | opf(4'b0010) | ((k == K_LD) ? MR : MW), "mem");
            end
            if (mwait > MAX_WAIT) begin
                expect_fault(3);
                return;
            end
            if (k == K_ST) begin
                bump();
                return;
            end
        end

        step(4, rand_bit(), rand_bit(), RW | ((k == K_LD) ? M2R : 14'h0), "wb");
        bump();
    endtask

    initial begin
        reset_n     = 1'b0;
        mem_ready   = 1'b0;
        zero        = 1'b0;
        instruction = 32'h0;
        @(negedge clock);
        do_reset();

        run_instr(I_ADD, 0, 0, -1);
        run_instr(I_LDUR, 0, 3, -1);
        run_instr(I_STUR, 0, 3, -1);
        run_instr(I_CBZ, 0, 0, 1);
        run_instr(I_CBZ, 0, 0, 0);
        run_instr(I_CBNZ, 0, 0, 1);
        run_instr(I_CBNZ, 0, 0, 0);
        run_instr(I_B, 0, 0, -1);
        run_instr(I_ADD, MAX_WAIT, 0, -1);
        run_instr(I_STUR, 1, MAX_WAIT, -1);

        for (int i = 0; i < 40; i++) begin
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        run_instr(I_ADD, MAX_WAIT + 1, 0, -1);
        do_reset();
        run_instr(I_LDUR, 0, MAX_WAIT + 1, -1);
        do_reset();

        run_instr(32'h0000_0000, 0, 0, -1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_ctrl", 32'(ctrl), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_ret = 0;

        for (int i = 0; i < 17; i++) run_instr(I_B, $urandom_range(0, 2), 0, -1);
        #1;
        check("wrap_retired", 32'(retired), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
